lut_mux_tree: RTL and testbench
===============================

Name: lut_mux_tree

Overview:
- Parametrised, pipelined K-input lookup-table gate built purely from a tree of 2:1 multiplexers.
- Applies one programmable Boolean function bitwise across W independent lanes.
- Next generation of our mux-built fixed gates: any K-input function, runtime reconfigurable, valid/ready streaming.
- Sits between combinational lab blocks and streaming datapaths as a reusable programmable logic cell.

Parameters:
- K, 2, number of function inputs (mux tree depth); legal range 1..6.
- W, 4, lanes evaluated in parallel.
- PIPELINE, 0, 0 = single output register; 1 = register after every mux level.
- RESET_TABLE, 4'b1000, truth table loaded at reset, width 2**K (default = AND for K=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_x  in  K*W  operands; operand i, lane j at bit i*W+j
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_y  out  W  result lanes
- cfg_valid  in  1  new truth table request
- cfg_ready  out  1  table written this cycle
- cfg_table  in  2**K  new truth table

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Function: out_y[j] = table[{x_{K-1}[j],...,x_0[j]}], where x_i is operand i.
  - Level 0 of the mux tree is selected by x_0 and level K-1 by x_{K-1}.
  - Tree leaves are the table bits.
- Latency from an accepted input to out_valid:
  - PIPELINE=0: 1 cycle.
  - PIPELINE=1: K cycles.
- Each pipeline stage carries a valid bit.
- Stall: stall = out_valid && !out_ready. While stalled, every stage, its valid bit, and out_y hold.
- No beat is dropped or duplicated.
- in_ready = (state==RUN) && !stall.
- Handshakes: a beat transfers when valid && ready.
  - in_x and cfg_table are sampled only on transfer.
  - cfg_valid must stay high, with cfg_table stable, until cfg_ready.
- FSM states RUN, DRAIN, LOAD:
  - RUN: accept traffic. cfg_valid=1 -> DRAIN next cycle. A data beat offered in that same cycle is still accepted.
  - DRAIN: in_ready=0. When all stage valid bits are 0 (output beat consumed), go to LOAD.
  - LOAD: cfg_ready=1 for exactly one cycle. table <= cfg_table if cfg_valid; otherwise no write. Always return to RUN.
- Ordering: beats accepted before DRAIN always use the old table; beats accepted after LOAD use the new table.
- Reset values:
  - Outputs: out_valid=0, out_y=0, cfg_ready=0, in_ready=0 during the reset cycle.
  - Internal: state=RUN, table=RESET_TABLE, all stage valid bits 0.
- Reset mid-operation: in-flight beats are discarded and a pending cfg request is dropped. The requester must re-assert after reset.
- Back-to-back throughput: 1 beat/cycle in RUN with out_ready=1.
- Width rules: table index is K bits unsigned; no arithmetic beyond that indexing.

Decomposition:
- Package lut_mux_pkg:
  - state enum {RUN, DRAIN, LOAD}.
  - localparam function tbl_w(K)=2**K.
  - Default RESET_TABLE constants: AND, OR, XOR for K=2.
- One sub-module, mux2_lanes: W-wide 2:1 mux with per-lane select.
  - Instantiated (2**K - 1) times via generate.
  - Per-level optional register controlled by PIPELINE.

Test Plan:
- Reset default (K=2, W=4, PIPELINE=0): x0=4'b1100, x1=4'b1010, out_ready=1 -> out_y=4'b1000, out_valid 1 cycle after accept.
- Reconfigure to XOR: cfg_table=4'b0110 with idle input -> cfg_ready after one DRAIN cycle. Same operands then give out_y=4'b0110.
- Backpressure (PIPELINE=1): stream 5 beats, out_ready=0 for 3 cycles mid-stream -> out_y/out_valid held, in_ready=0 while stalled, all 5 results in order.
- Config during traffic (PIPELINE=1, K=2): 3 beats in flight, cfg_valid=1 with OR table 4'b1110.
  - First 3 results use AND.
  - in_ready=0 until LOAD.
  - Next beat yields 4'b1110 for x0=4'b1100, x1=4'b1010.
- Reset mid-stream: rst_n=0 with 2 beats in flight and table=XOR -> next cycle out_valid=0. After release, table=AND and no stale beats emerge.
- K=3 majority: cfg_table=8'hE8, x0=4'b1100, x1=4'b1010, x2=4'b0110 -> out_y=4'b1110.

Source files
------------

// File: rtl/lut_mux_pkg.sv
// lut_mux_pkg: shared types and constants for the mux-tree lookup-table gate
package lut_mux_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    localparam logic [3:0] TBL_AND = 4'b1000;
    localparam logic [3:0] TBL_OR  = 4'b1110;
    localparam logic [3:0] TBL_XOR = 4'b0110;

    function automatic int tbl_w(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/mux2_lanes.sv
// mux2_lanes: W-lane 2:1 mux with per-lane select and optional output register
//   clk, rst_n : clock, synchronous active-low reset (register variant only)
//   en         : register load enable (pipeline advance)
//   a, b       : lane data for select 0 / select 1
//   sel        : per-lane select
//   y          : selected lanes, registered when REG=1
module mux2_lanes #(
    parameter int W   = 4,
    parameter bit REG = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] sel,
    output logic [W-1:0] y
);
    logic [W-1:0] m;

    assign m = (sel & b) | (~sel & a);

    if (REG) begin : g_reg
        always_ff @(posedge clk)
            if (!rst_n) y <= '0;
            else if (en) y <= m;
    end else begin : g_comb
        logic unused;
        assign unused = &{1'b0, clk, rst_n, en};
        assign y = m;
    end

endmodule

// File: rtl/lut_mux_tree.sv
// lut_mux_tree: pipelined, runtime-reconfigurable K-input LUT built from 2:1 muxes
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand beat handshake, in_x operand i lane j at bit i*W+j
//   out_valid/out_ready  : result handshake, out_y one bit per lane
//   cfg_valid/cfg_ready  : truth-table update handshake, cfg_table is the new table
module lut_mux_tree
    import lut_mux_pkg::*;
#(
    parameter int                     K           = 2,
    parameter int                     W           = 4,
    parameter int                     PIPELINE    = 0,
    parameter logic [tbl_w(K)-1:0]    RESET_TABLE = TBL_AND
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K*W-1:0]        in_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_y,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [tbl_w(K)-1:0]   cfg_table
);
    localparam int N  = tbl_w(K);
    localparam int NS = PIPELINE != 0 ? K : 1;

    state_t         state;
    logic [N-1:0]   tbl;
    logic [NS-1:0]  vs;
    logic [W-1:0]   node [1:2*N-1];
    logic           stall, en, acc;

    assign stall     = out_valid && !out_ready;
    assign en        = !stall;
    assign in_ready  = rst_n && state == RUN && !stall;
    assign cfg_ready = rst_n && state == LOAD;
    assign acc       = in_valid && in_ready;
    assign out_valid = vs[NS-1];

    // Heap-numbered tree: node n has children 2n (select 0) and 2n+1 (select 1);
    // leaves N..2N-1 are the table bits, node 1 is the root.
    genvar i;
    for (i = 0; i < N; i++) begin : g_leaf
        assign node[N+i] = {W{tbl[i]}};
    end

    // Operands delayed alongside the data so level L sees the beat it belongs to.
    if (PIPELINE != 0 && K > 1) begin : g_xp
        logic [K*W-1:0] q [K-1];
        always_ff @(posedge clk)
            if (en) begin
                q[0] <= in_x;
                for (int l = 1; l < K - 1; l++) q[l] <= q[l-1];
            end
    end

    for (i = 1; i < N; i++) begin : g_mux
        localparam int L = K - $clog2(i + 1);
        logic [W-1:0] sel;
        if (PIPELINE != 0 && L > 0) begin : g_s
            assign sel = g_xp.q[L-1][L*W +: W];
        end else begin : g_s
            assign sel = in_x[L*W +: W];
        end
        mux2_lanes #(.W(W), .REG(PIPELINE != 0)) u_mux (
            .clk, .rst_n, .en,
            .a(node[2*i]), .b(node[2*i+1]), .sel, .y(node[i])
        );
    end

    if (PIPELINE != 0) begin : g_out
        assign out_y = node[1];
    end else begin : g_out
        always_ff @(posedge clk)
            if (!rst_n) out_y <= '0;
            else if (en) out_y <= node[1];
    end

    always_ff @(posedge clk)
        if (!rst_n) vs <= '0;
        else if (en) vs <= (vs << 1) | NS'(acc);

    // The table only changes in LOAD, which is reached with every stage empty,
    // so no in-flight beat can observe a mix of old and new table bits.
    always_ff @(posedge clk)
        if (!rst_n) begin
            state <= RUN;
            tbl   <= RESET_TABLE;
        end else begin
            if (state == LOAD && cfg_valid) tbl <= cfg_table;
            state <= state == RUN ? (cfg_valid ? DRAIN : RUN) :
                     state == DRAIN ? (|vs ? DRAIN : LOAD) : RUN;
        end

endmodule

// File: tb/tb_lut_mux_tree.sv
// tb_lut_mux_tree: scoreboard bench over three parameterisations of lut_mux_tree
module tb_lut_mux_tree;
    import lut_mux_pkg::*;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;

    logic iv0 = 0, or0 = 1, cv0 = 0, ir0, ov0, cr0;
    logic [7:0] x0 = 0;
    logic [3:0] ct0 = 0, y0;
    logic iv1 = 0, or1 = 1, cv1 = 0, ir1, ov1, cr1;
    logic [7:0] x1 = 0;
    logic [3:0] ct1 = 0, y1;
    logic iv2 = 0, or2 = 1, cv2 = 0, ir2, ov2, cr2;
    logic [11:0] x2 = 0;
    logic [7:0] ct2 = 0;
    logic [3:0] y2;

    logic [3:0] q0[$], q1[$], q2[$];
    logic [7:0] mt0, mt1, mt2;
    int rx1 = 0, rx2 = 0;
    logic [3:0] last1, last2, py;
    int sent, acc;
    bit ws, seen;
    logic [7:0] pat [5] = '{8'h5C, 8'hA3, 8'hF0, 8'h96, 8'h3E};

    lut_mux_tree #(.K(2), .W(4), .PIPELINE(0), .RESET_TABLE(TBL_AND)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_x(x0),
        .out_valid(ov0), .out_ready(or0), .out_y(y0),
        .cfg_valid(cv0), .cfg_ready(cr0), .cfg_table(ct0));
    lut_mux_tree #(.K(2), .W(4), .PIPELINE(1), .RESET_TABLE(TBL_AND)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_x(x1),
        .out_valid(ov1), .out_ready(or1), .out_y(y1),
        .cfg_valid(cv1), .cfg_ready(cr1), .cfg_table(ct1));
    lut_mux_tree #(.K(3), .W(4), .PIPELINE(1), .RESET_TABLE(8'h80)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_x(x2),
        .out_valid(ov2), .out_ready(or2), .out_y(y2),
        .cfg_valid(cv2), .cfg_ready(cr2), .cfg_table(ct2));

    function automatic logic [3:0] model(logic [7:0] t, logic [11:0] x, int k);
        logic [3:0] r;
        logic [2:0] idx;
        for (int j = 0; j < 4; j++) begin
            idx = {k == 3 ? x[8+j] : 1'b0, x[4+j], x[j]};
            r[j] = t[idx];
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete(); q1.delete(); q2.delete();
            mt0 = {4'b0, TBL_AND}; mt1 = {4'b0, TBL_AND}; mt2 = 8'h80;
        end else begin
            if (ov0 && or0) begin
                chk("sb0_pending", q0.size() > 0, 1);
                if (q0.size() > 0) chk("sb0_y", y0, q0.pop_front());
            end
            if (ov1 && or1) begin
                rx1++; last1 = y1;
                chk("sb1_pending", q1.size() > 0, 1);
                if (q1.size() > 0) chk("sb1_y", y1, q1.pop_front());
            end
            if (ov2 && or2) begin
                rx2++; last2 = y2;
                chk("sb2_pending", q2.size() > 0, 1);
                if (q2.size() > 0) chk("sb2_y", y2, q2.pop_front());
            end
            if (iv0 && ir0) q0.push_back(model(mt0, {4'b0, x0}, 2));
            if (iv1 && ir1) q1.push_back(model(mt1, {4'b0, x1}, 2));
            if (iv2 && ir2) q2.push_back(model(mt2, x2, 3));
            if (cv0 && cr0) mt0 = {4'b0, ct0};
            if (cv1 && cr1) mt1 = {4'b0, ct1};
            if (cv2 && cr2) mt2 = ct2;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ov", ov0, 0); chk("rst_y", y0, 0); chk("rst_ir", ir0, 0);
        chk("rst_cr", cr0, 0); chk("rst_ov1", ov1, 0);
        cyc(); rst_n = 1;
        // default AND, single-cycle latency
        iv0 = 1; x0 = {4'b1010, 4'b1100};
        @(negedge clk); chk("t1_ir", ir0, 1);
        cyc(); iv0 = 0;
        @(negedge clk); chk("t1_ov", ov0, 1); chk("t1_y", y0, 4'b1000);
        cyc();
        @(negedge clk); chk("t1_idle", ov0, 0);
        cyc();
        // reconfigure to XOR with idle input
        cv0 = 1; ct0 = TBL_XOR;
        @(negedge clk); chk("t2_cr_run", cr0, 0);
        cyc();
        @(negedge clk); chk("t2_cr_drain", cr0, 0); chk("t2_ir_drain", ir0, 0);
        cyc();
        @(negedge clk); chk("t2_cr_load", cr0, 1);
        cyc(); cv0 = 0;
        @(negedge clk); chk("t2_cr_back", cr0, 0); chk("t2_ir_run", ir0, 1);
        cyc(); iv0 = 1;
        @(negedge clk);
        cyc(); iv0 = 0;
        @(negedge clk); chk("t2_ov", ov0, 1); chk("t2_y", y0, 4'b0110);
        cyc();
        // backpressure on the pipelined instance
        sent = 0; ws = 0; rx1 = 0;
        for (int c = 0; c < 20; c++) begin
            iv1 = sent < 5; x1 = pat[sent < 5 ? sent : 0]; or1 = !(c >= 4 && c < 7);
            @(negedge clk);
            if (ov1 && !or1) begin
                chk("t3_ir_stall", ir1, 0);
                if (ws) chk("t3_hold_y", y1, py);
                ws = 1; py = y1;
            end else ws = 0;
            if (iv1 && ir1) sent++;
            cyc();
        end
        iv1 = 0; or1 = 1;
        chk("t3_sent", sent, 5); chk("t3_rx", rx1, 5); chk("t3_q", q1.size(), 0);
        // config request while beats are in flight
        acc = 0; seen = 0; rx1 = 0; ct1 = TBL_OR;
        for (int c = 0; c < 20; c++) begin
            iv1 = acc < 4; x1 = acc < 3 ? pat[acc] : 8'hAC;
            cv1 = acc >= 2 && !seen;
            @(negedge clk);
            if (acc == 3 && !seen) chk("t4_ir_drain", ir1, 0);
            if (cv1 && cr1) seen = 1;
            if (iv1 && ir1) acc++;
            cyc();
        end
        iv1 = 0; cv1 = 0;
        chk("t4_seen", seen, 1); chk("t4_rx", rx1, 4); chk("t4_last", last1, 4'b1110);
        chk("t4_q", q1.size(), 0);
        // switch to XOR, then reset with two beats in flight
        seen = 0; ct1 = TBL_XOR;
        for (int c = 0; c < 10 && !seen; c++) begin
            cv1 = 1;
            @(negedge clk);
            if (cr1) seen = 1;
            cyc();
        end
        cv1 = 0; chk("t5_cfg", seen, 1);
        iv1 = 1; x1 = 8'h5C;
        @(negedge clk); chk("t5_ir_a", ir1, 1);
        cyc(); x1 = 8'hA3;
        @(negedge clk); chk("t5_ir_b", ir1, 1);
        cyc(); iv1 = 0; rst_n = 0;
        @(negedge clk);
        cyc();
        @(negedge clk); chk("t5_ov_rst", ov1, 0); chk("t5_y_rst", y1, 0);
        cyc(); rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk("t5_no_stale", ov1, 0);
            cyc();
        end
        rx1 = 0; iv1 = 1; x1 = 8'hAC;
        @(negedge clk);
        cyc(); iv1 = 0;
        for (int c = 0; c < 10 && rx1 == 0; c++) cyc();
        chk("t5_rx", rx1, 1); chk("t5_and", last1, 4'b1000);
        // K=3 majority
        seen = 0; ct2 = 8'hE8;
        for (int c = 0; c < 10 && !seen; c++) begin
            cv2 = 1;
            @(negedge clk);
            if (cr2) seen = 1;
            cyc();
        end
        cv2 = 0; chk("t6_cfg", seen, 1);
        rx2 = 0; iv2 = 1; x2 = {4'b0110, 4'b1010, 4'b1100};
        @(negedge clk); chk("t6_ir", ir2, 1);
        cyc(); iv2 = 0;
        for (int c = 0; c < 10 && rx2 == 0; c++) cyc();
        chk("t6_rx", rx2, 1); chk("t6_maj", last2, 4'b1110);
        repeat (3) cyc();
        chk("end_q0", q0.size(), 0); chk("end_q1", q1.size(), 0); chk("end_q2", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
